// File: rtl/axi_slave_responder_pkg.sv
// axi_slave_responder_pkg: AXI channel bundles and response codes shared by the responder and its bench.
package axi_slave_responder_pkg;
    localparam int ADDR_WIDTH     = 16;
    localparam int ID_W_WIDTH     = 5;
    localparam int ID_R_WIDTH     = 5;
    localparam int AXI_DATA_WIDTH = 32;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    typedef struct packed {
        logic [ID_W_WIDTH-1:0]       aw_id;
        logic [ADDR_WIDTH-1:0]       aw_addr;
        logic [7:0]                  aw_len;
        logic [2:0]                  aw_size;
        logic [1:0]                  aw_burst;
        logic                        aw_valid;
        logic [AXI_DATA_WIDTH-1:0]   w_data;
        logic [AXI_DATA_WIDTH/8-1:0] w_strb;
        logic                        w_last;
        logic                        w_valid;
        logic                        b_ready;
        logic [ID_R_WIDTH-1:0]       ar_id;
        logic [ADDR_WIDTH-1:0]       ar_addr;
        logic [7:0]                  ar_len;
        logic [2:0]                  ar_size;
        logic [1:0]                  ar_burst;
        logic                        ar_valid;
        logic                        r_ready;
    } axi_mosi_t;
    typedef struct packed {
        logic                      aw_ready;
        logic                      w_ready;
        logic [ID_W_WIDTH-1:0]     b_id;
        logic [1:0]                b_resp;
        logic                      b_valid;
        logic                      ar_ready;
        logic [ID_R_WIDTH-1:0]     r_id;
        logic [AXI_DATA_WIDTH-1:0] r_data;
        logic [1:0]                r_resp;
        logic                      r_last;
        logic                      r_valid;
    } axi_miso_t;
endpackage

// File: rtl/axi_slave_responder_fifo.sv
// axi_slave_responder_fifo: request queue whose ready is a register, so no valid->ready path exists.
module axi_slave_responder_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_ready, w_push, w_pop;
    assign w_push     = i_push && r_ready;
    assign w_pop      = i_pop && !o_empty;
    assign o_empty    = (r_cnt == '0);
    assign o_ready    = r_ready;
    assign o_data     = r_mem[r_rptr];
    assign w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
    // ready is precomputed from the next occupancy so it is exact on the following cycle
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_ready <= (w_cnt_next != CW'(DEPTH));
            if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        end
    end
endmodule

// File: rtl/axi_slave_responder.sv
// axi_slave_responder: AXI sink that answers queued writes/reads after a programmable delay,
// counting completions and flagging WLAST/AWLEN disagreement.
module axi_slave_responder
    import axi_slave_responder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int RESPONDER_ID = 0
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic [7:0]  resp_delay_i,
    input  axi_mosi_t   s_axi_i,
    output axi_miso_t   s_axi_o,
    output logic [15:0] wr_done_o,
    output logic [15:0] rd_done_o,
    output logic        err_o
);
    typedef enum logic [1:0] {WIDLE, WDATA, WDLY, WRESP} wr_state_t;
    typedef enum logic [1:0] {RIDLE, RDLY, RBURST} rd_state_t;
    wr_state_t             r_wstate;
    rd_state_t             r_rstate;
    logic [ID_W_WIDTH-1:0] r_wid;
    logic [ID_R_WIDTH-1:0] r_rid;
    logic [7:0]            r_wlen, r_wbeat, r_wcnt, r_rlen, r_rbeat, r_rcnt;
    logic [1:0]            r_bresp;
    logic                  r_wready, r_bvalid, r_rvalid, r_err;
    logic [15:0]           r_wr_done, r_rd_done;
    logic [7+ID_W_WIDTH:0] w_aw_head;
    logic [7+ID_R_WIDTH:0] w_ar_head;
    logic                  w_aw_ready, w_aw_empty, w_aw_pop, w_ar_ready, w_ar_empty, w_ar_pop;
    logic                  w_rlast, w_wmis, w_unused;
    assign w_aw_pop = (r_wstate == WIDLE) && !w_aw_empty;
    assign w_ar_pop = (r_rstate == RIDLE) && !w_ar_empty;
    assign w_rlast  = (r_rbeat == r_rlen);
    assign w_wmis   = (r_wbeat != r_wlen);
    assign w_unused = ^{s_axi_i.aw_addr, s_axi_i.aw_size, s_axi_i.aw_burst, s_axi_i.w_data,
                        s_axi_i.w_strb, s_axi_i.ar_addr, s_axi_i.ar_size, s_axi_i.ar_burst};
    axi_slave_responder_fifo #(.WIDTH(8 + ID_W_WIDTH), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
        .clk_i(clk_i), .arstn_i(arstn_i), .i_push(s_axi_i.aw_valid),
        .i_data({s_axi_i.aw_len, s_axi_i.aw_id}), .o_ready(w_aw_ready),
        .i_pop(w_aw_pop), .o_data(w_aw_head), .o_empty(w_aw_empty)
    );
    axi_slave_responder_fifo #(.WIDTH(8 + ID_R_WIDTH), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
        .clk_i(clk_i), .arstn_i(arstn_i), .i_push(s_axi_i.ar_valid),
        .i_data({s_axi_i.ar_len, s_axi_i.ar_id}), .o_ready(w_ar_ready),
        .i_pop(w_ar_pop), .o_data(w_ar_head), .o_empty(w_ar_empty)
    );
    always_comb begin
        s_axi_o          = '0;
        s_axi_o.aw_ready = w_aw_ready;
        s_axi_o.w_ready  = r_wready;
        s_axi_o.b_id     = r_wid;
        s_axi_o.b_resp   = r_bresp;
        s_axi_o.b_valid  = r_bvalid;
        s_axi_o.ar_ready = w_ar_ready;
        s_axi_o.r_id     = r_rid;
        s_axi_o.r_data   = r_rvalid ? AXI_DATA_WIDTH'({8'(RESPONDER_ID), r_rbeat}) : '0;
        s_axi_o.r_resp   = AXI_RESP_OKAY;
        s_axi_o.r_last   = r_rvalid && w_rlast;
        s_axi_o.r_valid  = r_rvalid;
    end
    assign wr_done_o = r_wr_done;
    assign rd_done_o = r_rd_done;
    assign err_o     = r_err;
    // both FSMs share one register block; the delay counters load on the transition into the delay state
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wstate  <= WIDLE;
            r_rstate  <= RIDLE;
            r_wid     <= '0;
            r_rid     <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
            r_wcnt    <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rcnt    <= '0;
            r_bresp   <= AXI_RESP_OKAY;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_wr_done <= '0;
            r_rd_done <= '0;
        end else begin
            case (r_wstate)
                WIDLE: if (!w_aw_empty) begin
                    {r_wlen, r_wid} <= w_aw_head;
                    r_wbeat  <= '0;
                    r_wready <= 1'b1;
                    r_wstate <= WDATA;
                end
                WDATA: if (s_axi_i.w_valid) begin
                    r_wbeat <= r_wbeat + 8'd1;
                    if (s_axi_i.w_last) begin
                        r_bresp  <= w_wmis ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        r_err    <= r_err | w_wmis;
                        r_wready <= 1'b0;
                        r_wcnt   <= resp_delay_i;
                        r_bvalid <= (resp_delay_i == 8'd0);
                        r_wstate <= (resp_delay_i == 8'd0) ? WRESP : WDLY;
                    end else if (!w_wmis) r_err <= 1'b1;
                end
                WDLY: begin
                    r_wcnt <= r_wcnt - 8'd1;
                    if (r_wcnt == 8'd1) begin
                        r_bvalid <= 1'b1;
                        r_wstate <= WRESP;
                    end
                end
                WRESP: if (s_axi_i.b_ready) begin
                    r_bvalid  <= 1'b0;
                    r_wr_done <= r_wr_done + 16'd1;
                    r_wstate  <= WIDLE;
                end
                default: r_wstate <= WIDLE;
            endcase
            case (r_rstate)
                RIDLE: if (!w_ar_empty) begin
                    {r_rlen, r_rid} <= w_ar_head;
                    r_rbeat  <= '0;
                    r_rcnt   <= resp_delay_i;
                    r_rvalid <= (resp_delay_i == 8'd0);
                    r_rstate <= (resp_delay_i == 8'd0) ? RBURST : RDLY;
                end
                RDLY: begin
                    r_rcnt <= r_rcnt - 8'd1;
                    if (r_rcnt == 8'd1) begin
                        r_rvalid <= 1'b1;
                        r_rstate <= RBURST;
                    end
                end
                RBURST: if (s_axi_i.r_ready) begin
                    if (w_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rd_done <= r_rd_done + 16'd1;
                        r_rstate  <= RIDLE;
                    end else r_rbeat <= r_rbeat + 8'd1;
                end
                default: r_rstate <= RIDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_responder.sv
// tb_axi_slave_responder: directed and randomized transactions against a transaction-level expectation model.
module tb_axi_slave_responder;
    import axi_slave_responder_pkg::*;
    localparam int RID = 3;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [7:0]  dly = '0;
    axi_mosi_t   mosi;
    axi_miso_t   miso;
    logic [15:0] wr_done, rd_done;
    logic        err;
    int checks = 0, failures = 0, cyc = 0, wr_m = 0, rd_m = 0;

    axi_slave_responder #(.FIFO_DEPTH(8), .RESPONDER_ID(RID)) dut (
        .clk_i(clk), .arstn_i(arstn), .resp_delay_i(dly), .s_axi_i(mosi), .s_axi_o(miso),
        .wr_done_o(wr_done), .rd_done_o(rd_done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [4:0] id, input logic [7:0] len, output int c);
        int n = 0;
        mosi.aw_id = id; mosi.aw_len = len; mosi.aw_addr = 16'($urandom);
        mosi.aw_size = 3'd2; mosi.aw_burst = AXI_BURST_INCR; mosi.aw_valid = 1'b1;
        while (!miso.aw_ready && n < 300) begin tick(); n++; end
        chk("aw_accept", n < 300, 1);
        tick(); c = cyc; mosi.aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [4:0] id, input logic [7:0] len, output int c);
        int n = 0;
        mosi.ar_id = id; mosi.ar_len = len; mosi.ar_addr = 16'($urandom);
        mosi.ar_size = 3'd2; mosi.ar_burst = AXI_BURST_INCR; mosi.ar_valid = 1'b1;
        while (!miso.ar_ready && n < 300) begin tick(); n++; end
        chk("ar_accept", n < 300, 1);
        tick(); c = cyc; mosi.ar_valid = 1'b0;
    endtask

    task automatic w_send(input int last_at, input bit stall, output int c);
        int n;
        for (int k = 0; k <= last_at; k++) begin
            if (stall) repeat ($urandom_range(0, 2)) tick();
            mosi.w_valid = 1'b1; mosi.w_data = $urandom; mosi.w_strb = '1; mosi.w_last = (k == last_at);
            n = 0;
            while (!miso.w_ready && n < 300) begin tick(); n++; end
            chk("w_accept", n < 300, 1);
            tick(); mosi.w_valid = 1'b0; mosi.w_last = 1'b0;
        end
        c = cyc;
    endtask

    task automatic b_get(input logic [4:0] id, input logic [1:0] resp, input int hold, input int c_last, input int lat);
        int n = 0;
        mosi.b_ready = 1'b0;
        while (!miso.b_valid && n < 300) begin tick(); n++; end
        chk("b_latency", cyc - c_last + 1, lat);
        chk("b_id", miso.b_id, id);
        chk("b_resp", miso.b_resp, resp);
        repeat (hold) begin
            tick();
            chk("b_hold", {miso.b_valid, miso.b_id, miso.b_resp}, {1'b1, id, resp});
        end
        mosi.b_ready = 1'b1; tick(); mosi.b_ready = 1'b0; wr_m++;
        chk("b_drop", miso.b_valid, 0);
        chk("wr_done", wr_done, 16'(wr_m));
    endtask

    task automatic r_get(input logic [4:0] id, input logic [7:0] len, input bit stall, input int c_ar, input bit chk_lat, input int lat);
        int n;
        for (int k = 0; k <= int'(len); k++) begin
            n = 0;
            while (!miso.r_valid && n < 300) begin tick(); n++; end
            if (chk_lat && k == 0) chk("r_latency", cyc - c_ar + 1, lat);
            chk("r_id", miso.r_id, id);
            chk("r_data", miso.r_data, 32'(RID * 256 + k));
            chk("r_last", miso.r_last, k == int'(len));
            chk("r_resp", miso.r_resp, AXI_RESP_OKAY);
            if (stall) repeat ($urandom_range(0, 2)) begin
                mosi.r_ready = 1'b0; tick();
                chk("r_hold", {miso.r_valid, miso.r_last, miso.r_data}, {1'b1, k == int'(len), 32'(RID * 256 + k)});
            end
            mosi.r_ready = 1'b1; tick();
            if (stall) mosi.r_ready = 1'b0;
        end
        mosi.r_ready = 1'b0; rd_m++;
        chk("r_end", miso.r_valid, 0);
        chk("rd_done", rd_done, 16'(rd_m));
    endtask

    initial begin
        int c, c1, c2, acc, n;
        int lens[10];
        logic [4:0] id;
        logic [7:0] len;
        mosi = '0;
        repeat (3) tick();
        chk("rst_miso", miso, '0);
        chk("rst_cnt", {wr_done, rd_done, err}, '0);
        arstn = 1'b1; tick(); tick();
        chk("rdy_after_rst", {miso.aw_ready, miso.ar_ready, miso.w_ready}, 3'b110);
        // single 4-beat write, zero delay
        dly = 8'd0;
        aw_send(5'd5, 8'd3, c);
        n = 0;
        while (!miso.w_ready && n < 50) begin tick(); n++; end
        chk("aw_to_wready", cyc - c + 1, 2);
        w_send(3, 1'b0, c);
        b_get(5'd5, AXI_RESP_OKAY, 0, c, 1);
        // randomized clean writes and reads
        for (int it = 0; it < 6; it++) begin
            dly = 8'($urandom_range(0, 5));
            id = 5'($urandom); len = 8'($urandom_range(0, 7));
            aw_send(id, len, c);
            w_send(int'(len), 1'b1, c);
            b_get(id, AXI_RESP_OKAY, $urandom_range(0, 3), c, int'(dly) + 1);
            id = 5'($urandom); len = 8'($urandom_range(0, 7));
            ar_send(id, len, c);
            r_get(id, len, 1'b1, c, 1'b1, int'(dly) + 2);
        end
        chk("err_clean", err, 0);
        // 8-beat read after a 4-cycle delay
        dly = 8'd4;
        ar_send(5'd2, 8'd7, c);
        r_get(5'd2, 8'd7, 1'b0, c, 1'b1, 6);
        // stalled 4-beat read
        dly = 8'd1;
        ar_send(5'd9, 8'd3, c);
        r_get(5'd9, 8'd3, 1'b1, c, 1'b1, 3);
        // AR queue saturation with RREADY low
        for (int i = 0; i < 10; i++) lens[i] = $urandom_range(0, 3);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            mosi.ar_id = 5'(i); mosi.ar_len = 8'(lens[i]); mosi.ar_valid = 1'b1;
            n = 0;
            while (!miso.ar_ready && n < 20) begin tick(); n++; end
            if (n == 20) break;
            tick(); acc++;
        end
        if (acc == 10) mosi.ar_valid = 1'b0;
        chk("ar_accepted", acc, 9);
        chk("ar_ready_low", miso.ar_ready, 0);
        fork
            begin if (acc < 10) ar_send(5'd9, 8'(lens[9]), c1); end
            begin for (int i = 0; i < 10; i++) r_get(5'(i), 8'(lens[i]), 1'b0, 0, 1'b0, 0); end
        join
        // short WLAST then a clean write; error stays sticky
        dly = 8'd2;
        aw_send(5'd7, 8'd3, c);
        w_send(2, 1'b0, c);
        b_get(5'd7, AXI_RESP_SLVERR, 1, c, 3);
        chk("err_set", err, 1);
        aw_send(5'd8, 8'd1, c);
        w_send(1, 1'b1, c);
        b_get(5'd8, AXI_RESP_OKAY, 0, c, 3);
        chk("err_sticky", err, 1);
        // reset clears counters and error; then a late WLAST
        arstn = 1'b0; tick(); arstn = 1'b1; tick();
        wr_m = 0; rd_m = 0;
        chk("rst2_cnt", {wr_done, rd_done, err}, '0);
        dly = 8'd0;
        aw_send(5'd3, 8'd1, c);
        w_send(2, 1'b0, c);
        b_get(5'd3, AXI_RESP_SLVERR, 0, c, 1);
        chk("err_late_last", err, 1);
        // concurrent write (BREADY held off) and read
        dly = 8'd2;
        fork
            begin aw_send(5'd11, 8'd3, c1); w_send(3, 1'b1, c1); b_get(5'd11, AXI_RESP_OKAY, 20, c1, 3); end
            begin ar_send(5'd4, 8'd3, c2); r_get(5'd4, 8'd3, 1'b1, c2, 1'b1, 4); end
        join
        // reset in the middle of a read burst and a write burst
        dly = 8'd0;
        aw_send(5'd1, 8'd7, c1);
        mosi.w_valid = 1'b1; mosi.r_ready = 1'b1;
        ar_send(5'd6, 8'd7, c2);
        repeat (4) tick();
        arstn = 1'b0; #1;
        chk("midrst_miso", miso, '0);
        chk("midrst_cnt", {wr_done, rd_done, err}, '0);
        mosi = '0; tick(); arstn = 1'b1;
        wr_m = 0; rd_m = 0;
        repeat (10) tick();
        chk("post_rst_idle", {miso.b_valid, miso.r_valid, miso.w_ready}, 3'b000);
        ar_send(5'd2, 8'd0, c);
        r_get(5'd2, 8'd0, 1'b0, c, 1'b1, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
